// File: rtl/mem_burst_master_if.sv
// Purpose: TOY main memory read/write port bundle (8-bit word address, 16-bit data).
// Latency: a request is taken in a cycle with val && rdy; read data follows one cycle later.
// Backpressure: rdy low (e.g. during the post-reset wipe) holds the requester off.
interface mem_rwport;
  logic        val;
  logic        wen;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdy;

  modport master (output val, wen, addr, wdata, input rdata, rdy);
  modport slave  (input val, wen, addr, wdata, output rdata, rdy);
endinterface

// File: rtl/mem_burst_master.sv
// Purpose: small synchronous FIFO with visible head and occupancy level.
// Latency: a push shows at the head on the next cycle; push and pop may share a cycle.
// Backpressure: pushes while full and pops while empty are dropped; the user keeps this from happening.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic [AW:0]   level
);
  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & (count != FULL);
  assign do_pop   = pop & (count != '0);
  assign head_dat = store[rd_ptr];
  assign empty    = (count == '0);
  assign level    = count;

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_dat;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// Purpose: burst master moving 16-bit words between host streams and the TOY memory port.
// Latency: first memory request the cycle after command accept; read data reaches rd_data_o two cycles after issue.
// Backpressure: writes follow mem rdy combinationally; reads stop issuing once 2 words are buffered or in flight.
module mem_burst_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_val_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_wen_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  input  logic        wr_val_i,
  output logic        wr_rdy_o,
  input  logic [15:0] wr_data_i,
  output logic        rd_val_o,
  input  logic        rd_rdy_i,
  output logic [15:0] rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  mem_rwport.master   mem
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cur_addr;
  logic [8:0]  remain;
  logic        inflight;
  logic        done_q;
  logic        done_nxt;
  logic [1:0]  level;
  logic        fifo_empty;
  logic        pop;
  logic        accept;
  logic        last;
  logic [2:0]  credits;
  logic        issue_ok;
  logic        drained;

  // Read data lands one cycle after acceptance and is parked here until the host takes it.
  sync_fifo #(.W(16), .DEPTH(2)) u_rd_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (inflight),
    .push_dat (mem.rdata),
    .pop      (pop),
    .head_dat (rd_data_o),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign rd_val_o = ~fifo_empty;
  assign pop      = rd_val_o & rd_rdy_i;
  assign accept   = mem.val & mem.rdy;
  assign last     = (remain == 9'd1);
  // A credit is either a buffered word or a read whose data arrives next cycle.
  assign credits  = {1'b0, level} + {2'b00, inflight};
  assign issue_ok = (credits < 3'd2) || ((credits == 3'd2) && pop);
  // Look ahead by this cycle's pop so completion is flagged the cycle after the last word leaves.
  assign drained  = !inflight && ((level == 2'd0) || ((level == 2'd1) && pop));
  assign busy_o   = (state != IDLE);
  assign done_o   = done_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, memory-port drive and stream handshakes.
  always_comb begin
    state_nxt = state;
    cmd_rdy_o = 1'b0;
    wr_rdy_o  = 1'b0;
    mem.val   = 1'b0;
    mem.wen   = 1'b0;
    mem.addr  = 8'h00;
    mem.wdata = 16'h0000;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy_o = 1'b1;
        if (cmd_val_i) state_nxt = cmd_wen_i ? WRITE : READ;
      end
      WRITE: begin
        mem.val   = wr_val_i;
        mem.wen   = 1'b1;
        mem.addr  = cur_addr;
        mem.wdata = wr_data_i;
        wr_rdy_o  = mem.rdy;
        if (wr_val_i && mem.rdy && last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      READ: begin
        mem.val  = issue_ok;
        mem.addr = cur_addr;
        if (issue_ok && mem.rdy && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drained) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address/count, in-flight read flag and the registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_addr <= 8'h00;
      remain   <= 9'd0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= done_nxt;
      inflight <= (state == READ) && accept;
      if ((state == IDLE) && cmd_val_i) begin
        cur_addr <= cmd_addr_i;
        remain   <= {1'b0, cmd_len_i} + 9'd1;
      end else if (accept) begin
        cur_addr <= cur_addr + 8'd1;
        remain   <= remain - 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural memory behind the port.
// Cycle 0 is the command cycle; events are logged per cycle and compared with hand values.
// A side model tracks read credits and flags any overfill or issue with credits exhausted.
module tb_mem_burst_master;
  logic        clk_i;
  logic        rst_ni;
  logic        cmd_val, cmd_rdy, cmd_wen;
  logic [7:0]  cmd_addr, cmd_len;
  logic        wr_val, wr_rdy;
  logic [15:0] wr_data;
  logic        rd_val, rd_rdy;
  logic [15:0] rd_data;
  logic        busy, done;
  logic        mem_rdy;
  logic [15:0] mem_rdata;
  logic [15:0] mem_arr [256];

  mem_rwport mem_if ();
  assign mem_if.rdy   = mem_rdy;
  assign mem_if.rdata = mem_rdata;

  mem_burst_master dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cmd_val_i  (cmd_val),
    .cmd_rdy_o  (cmd_rdy),
    .cmd_wen_i  (cmd_wen),
    .cmd_addr_i (cmd_addr),
    .cmd_len_i  (cmd_len),
    .wr_val_i   (wr_val),
    .wr_rdy_o   (wr_rdy),
    .wr_data_i  (wr_data),
    .rd_val_o   (rd_val),
    .rd_rdy_i   (rd_rdy),
    .rd_data_o  (rd_data),
    .busy_o     (busy),
    .done_o     (done),
    .mem        (mem_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Memory model: writes land at the edge, read data appears the cycle after acceptance.
  always @(posedge clk_i) begin
    if (mem_if.val && mem_if.rdy) begin
      if (mem_if.wen) mem_arr[mem_if.addr] <= mem_if.wdata;
      else            mem_rdata <= mem_arr[mem_if.addr];
    end
  end

  // Independent credit model: occupancy + in-flight must never exceed 2.
  int viol = 0;
  int m_occ;
  int m_infl;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_occ  <= 0;
      m_infl <= 0;
    end else begin
      if (mem_if.val && !mem_if.wen && (m_occ + m_infl == 2) && !(rd_val && rd_rdy)) viol <= viol + 1;
      if (rd_val != (m_occ != 0)) viol <= viol + 1;
      if (m_occ + m_infl - ((rd_val && rd_rdy) ? 1 : 0) > 2) viol <= viol + 1;
      m_occ  <= m_occ + m_infl - ((rd_val && rd_rdy) ? 1 : 0);
      m_infl <= (mem_if.val && mem_if.rdy && !mem_if.wen) ? 1 : 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] wsrc [256];
  int          hits [256];
  logic [15:0] rq [$];
  int first_acc, last_acc, n_acc, first_rv, last_pop, n_pop, done_cyc, done_cnt;

  // Issue one command in cycle 0 and run until done_o (or the budget) while logging events.
  task automatic run_burst(input logic wen, input logic [7:0] addr, input logic [7:0] len,
                           input bit toggle, input int rdy_from, input int budget);
    int wr_idx;
    wr_idx = 0;
    first_acc = -1; last_acc = -1; n_acc = 0; first_rv = -1;
    last_pop = -1; n_pop = 0; done_cyc = -1; done_cnt = 0;
    rq.delete();
    cmd_val = 1'b1; cmd_wen = wen; cmd_addr = addr; cmd_len = len;
    for (int c = 0; c < budget; c++) begin
      wr_val  = wen && (wr_idx <= int'(len));
      wr_data = wsrc[wr_idx[7:0]];
      rd_rdy  = toggle ? (c % 2 == 0) : 1'b1;
      mem_rdy = (c >= rdy_from);
      @(negedge clk_i);
      if (mem_if.val && mem_if.rdy) begin
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        n_acc++;
        if (mem_if.wen) hits[mem_if.addr]++;
      end
      if (rd_val && first_rv < 0) first_rv = c;
      if (rd_val && rd_rdy) begin
        rq.push_back(rd_data);
        last_pop = c;
        n_pop++;
      end
      if (done && c > 0) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (wr_val && wr_rdy) wr_idx++;
      @(posedge clk_i); #1;
      cmd_val = 1'b0;
      if (done_cyc >= 0) break;
    end
    wr_val = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, cmd_rdy, 1);
    check({tag, "_flags"}, {busy, done, wr_rdy, rd_val, mem_if.val, mem_if.wen}, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_mem_addr"}, mem_if.addr, 0);
    check({tag, "_mem_wdata"}, mem_if.wdata, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [15:0] d;
    rst_ni = 1'b0; mem_rdy = 1'b0;
    cmd_val = 0; cmd_wen = 0; cmd_addr = 0; cmd_len = 0;
    wr_val = 0; wr_data = 0; rd_rdy = 0;
    for (int i = 0; i < 256; i++) begin wsrc[i] = 16'h0; hits[i] = 0; end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1; mem_rdy = 1'b1;
    @(posedge clk_i); #1;

    // Write 4 words at 0x10.
    for (int i = 0; i < 4; i++) wsrc[i] = 16'hA001 + 16'(i);
    run_burst(1'b1, 8'h10, 8'd3, 1'b0, 0, 20);
    check("wr4_first_acc", first_acc, 1);
    check("wr4_last_acc", last_acc, 4);
    check("wr4_done_cyc", done_cyc, 5);
    check("wr4_done_cnt", done_cnt, 1);
    for (int i = 0; i < 4; i++) check("wr4_mem", mem_arr[8'h10 + 8'(i)], 16'hA001 + i);

    // Read them back with the host always ready.
    run_burst(1'b0, 8'h10, 8'd3, 1'b0, 0, 20);
    check("rd4_first_acc", first_acc, 1);
    check("rd4_last_acc", last_acc, 4);
    check("rd4_first_rv", first_rv, 3);
    check("rd4_last_pop", last_pop, 6);
    check("rd4_n_pop", n_pop, 4);
    check("rd4_done_cyc", done_cyc, 7);
    for (int i = 0; i < rq.size(); i++) check("rd4_data", rq[i], 16'hA001 + i);

    // 8 words at 0x40, then read them with a toggling host ready.
    for (int i = 0; i < 8; i++) wsrc[i] = 16'hB000 + 16'(i);
    run_burst(1'b1, 8'h40, 8'd7, 1'b0, 0, 30);
    check("wr8_done_cyc", done_cyc, 9);
    run_burst(1'b0, 8'h40, 8'd7, 1'b1, 0, 80);
    check("rd8bp_n_pop", n_pop, 8);
    check("rd8bp_first_rv", first_rv, 3);
    check("rd8bp_done_cnt", done_cnt, 1);
    for (int i = 0; i < rq.size(); i++) check("rd8bp_data", rq[i], 16'hB000 + i);
    check("rd8bp_credit_model", viol, 0);

    // Full 256-word write starting at 0xFE, wrapping through 0x00.
    for (int i = 0; i < 256; i++) begin wsrc[i] = 16'hC000 + 16'(i); hits[i] = 0; end
    run_burst(1'b1, 8'hFE, 8'hFF, 1'b0, 0, 300);
    check("wr256_n_acc", n_acc, 256);
    check("wr256_done_cyc", done_cyc, 257);
    check("wr256_done_cnt", done_cnt, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (hits[i] != 1) bad++;
    check("wr256_addr_hits", bad, 0);
    check("wr256_mem_fe", mem_arr[8'hFE], 16'hC000);
    check("wr256_mem_ff", mem_arr[8'hFF], 16'hC001);
    check("wr256_mem_00", mem_arr[8'h00], 16'hC002);
    check("wr256_mem_fd", mem_arr[8'hFD], 16'hC0FF);
    @(negedge clk_i);
    check("wr256_done_once", {busy, done}, 0);
    @(posedge clk_i); #1;

    // Command straight after reset while memory is still wiping (rdy rises in cycle 4).
    rst_ni = 1'b0; mem_rdy = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    wsrc[0] = 16'hD001; wsrc[1] = 16'hD002;
    run_burst(1'b1, 8'h80, 8'd1, 1'b0, 4, 30);
    check("wipe_first_acc", first_acc, 4);
    check("wipe_last_acc", last_acc, 5);
    check("wipe_done_cyc", done_cyc, 6);
    check("wipe_mem_80", mem_arr[8'h80], 16'hD001);
    check("wipe_mem_81", mem_arr[8'h81], 16'hD002);

    // Reset in the middle of an 8-word read, then a fresh 1-word read.
    run_burst(1'b0, 8'h40, 8'd7, 1'b0, 0, 4);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("midrst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_burst(1'b0, 8'h81, 8'd0, 1'b0, 0, 20);
    check("rd1_n_pop", n_pop, 1);
    check("rd1_first_rv", first_rv, 3);
    check("rd1_done_cyc", done_cyc, 4);
    d = (rq.size() > 0) ? rq[0] : 16'h0000;
    check("rd1_data", d, 16'hD002);
    check("credit_model_total", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Burst master for the TOY main memory read/write port: it accepts a command (start address, word count, direction) and moves a burst of 16-bit words between a host stream and memory. Write bursts take words from a valid/ready input stream. Read bursts return words on a valid/ready output stream with full backpressure. It drives the `mem_rwport.master` side and is the block used by the front-panel loader and by the debug dump path.

## Interface
- No parameters. Address width 8 and data width 16 are fixed by `mem_rwport`.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `cmd_val_i`  in  1  command valid.
- `cmd_rdy_o`  out  1  command ready; high only in IDLE.
- `cmd_wen_i`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr_i`  in  8  start word address.
- `cmd_len_i`  in  8  word count minus 1 (so 0 → 1 word, 255 → 256 words).
- `wr_val_i` / `wr_rdy_o` / `wr_data_i`  in / out / in  1 / 1 / 16  write-data stream.
- `rd_val_o` / `rd_rdy_i` / `rd_data_o`  out / in / out  1 / 1 / 16  read-data stream.
- `busy_o`  out  1  high whenever state ≠ IDLE.
- `done_o`  out  1  one-cycle pulse marking burst completion.
- `mem`  `mem_rwport.master`  bundle  drives `val`, `wen`, `addr`, `wdata`; samples `rdata`, `rdy`.

## Operation
- The memory-port rule:
  - A request is accepted in a cycle with `val && rdy`.
  - For a read, `rdata` is valid in the cycle after acceptance.
  - `rdy` is low while memory is wiping after reset; requests wait.
- States are IDLE, WRITE, READ, DRAIN.
- IDLE:
  - `cmd_rdy_o` = 1; all `mem` outputs are 0.
  - `cmd_val_i` with `cmd_wen_i`=1 captures addr/len and goes to WRITE.
  - `cmd_val_i` with `cmd_wen_i`=0 does the same and goes to READ.
- WRITE:
  - Combinational pass-through: `mem.val` = `wr_val_i`, `mem.wen` = 1, `mem.wdata` = `wr_data_i`, `wr_rdy_o` = `mem.rdy`.
  - Each accepted request increments the address and decrements the remaining count.
  - The last acceptance moves the block to IDLE.
- READ:
  - `mem.wen` = 0.
  - The block issues reads into a 2-entry output FIFO and tracks credits (occupancy + in-flight).
  - A read may issue when credits < 2, or credits = 2 and the FIFO pops this cycle.
  - After the last read is accepted, go to DRAIN.
- DRAIN: wait until the FIFO is empty and no read is in flight, then go to IDLE.
- FIFO rules:
  - `rd_data_o` is the FIFO head; `rd_val_o` = FIFO not empty.
  - `mem.rdata` is written in the cycle after acceptance.
  - A push and a pop in the same cycle are both honoured.
  - Overflow is impossible by the credit rule; the bench asserts it never happens.
- Address arithmetic:
  - 8-bit, wraps 0xFF → 0x00.
  - The count is a 9-bit down-counter loaded with `cmd_len_i`+1.
- `done_o` is registered and is high during the first IDLE cycle after WRITE or DRAIN. A new command may be accepted in that same cycle.
- `wr_rdy_o` = 0 outside WRITE; write-stream data is ignored outside WRITE.
- Reset mid-burst:
  - The burst is abandoned and FIFO and counters are cleared.
  - Memory writes already done are not undone.
  - No `done_o` pulse is generated.

## Timing
- Reset values:
  - `cmd_rdy_o` = 1 after reset (IDLE).
  - All other outputs = 0: `busy_o`, `done_o`, `wr_rdy_o`, `rd_val_o`, `rd_data_o`, `mem.val`, `mem.wen`, `mem.addr`, `mem.wdata`.
- Command accepted at cycle 0: `busy_o` is high and the first `mem.val` can assert in cycle 1.
- Write burst of N words, with `wr_val_i` and `mem.rdy` held high:
  - Accepts occur in cycles 1..N.
  - `done_o` is high in cycle N+1.
- Read burst of N words, with `rd_rdy_i` and `mem.rdy` held high:
  - Reads issue in cycles 1..N.
  - `rd_val_o` is first high in cycle 3 and stays high for N cycles.
  - `done_o` is high in the cycle after the last pop (cycle N+3).
- Sustained throughput is 1 word/cycle in both directions.
- Under read backpressure, at most 2 words are buffered or in flight. `mem.val` drops within the same cycle that credits reach 2 with no pop.

## Test plan
- Write 4 words 0xA001..0xA004 at addr 0x10, all ready → memory 0x10..0x13 hold those words; `done_o` in cycle 5.
- Read back 0x10..0x13 with `rd_rdy_i`=1 → `rd_data_o` 0xA001..0xA004 in cycles 3..6; `done_o` in cycle 7.
- Read 8 words with `rd_rdy_i` toggling 1/0 each cycle → data in order, no loss or duplication; `mem.val` never asserted with credits full and no pop.
- Write `cmd_len_i`=255 at addr 0xFE → all 256 addresses written, wrapping 0xFF → 0x00; `done_o` once.
- Issue a command right after reset while memory `rdy`=0 → no accepts until `rdy` rises; the burst then completes correctly.
- Assert `rst_ni` low mid-read-burst → next cycle all outputs hold their reset values; a new 1-word read afterwards returns correct data.
